// File: rtl/bsg_mesh_endpoint.sv
// -----------------------------------------------------------------------------
// bsg_mesh_endpoint
//
// Network endpoint sitting on the P (processor) port of one mesh router.
//
//   Injection: client requests are formatted into packets
//              {src_y, src_x, payload, dest_y, dest_x} (LSB last) and queued in
//              a 2-entry FIFO that drives the router under valid/yumi.
//   Ejection:  packets from the router are accepted under valid/ready_and into
//              a 2-entry FIFO, checked against this tile's coordinates, and
//              handed to the client under valid/yumi.
//
// Ports
//   clk_i, reset_n_i            clock, asynchronous active-low reset
//   my_x_i, my_y_i              this tile's coordinates (static after reset)
//   req_v_i / req_ready_o       client request handshake
//   req_dest_x_i, req_dest_y_i  request destination
//   req_payload_i               request payload
//   quiesce_i                   level, blocks new requests
//   link_v_o / link_yumi_i      packet to router P input
//   link_data_o                 head packet of the injection FIFO
//   link_v_i / link_ready_and_o packet from router P output
//   link_data_i                 incoming packet
//   resp_v_o / resp_yumi_i      delivered-packet handshake
//   resp_payload_o              delivered payload
//   resp_src_x_o, resp_src_y_o  source tile of delivered packet
//   idle_o                      both FIFOs empty
//   misroute_o                  sticky: a packet arrived for another tile
//   sent_cnt_o, recv_cnt_o      packet statistics
//
// Configuration
//   BSG_MESH_ENDPOINT_STATS_EN  defined: sent/recv counters are built.
//                               undefined: both counter outputs tied to 0.
// -----------------------------------------------------------------------------
module bsg_mesh_endpoint #(
    parameter int x_cord_width_p  = 1,
    parameter int y_cord_width_p  = 1,
    parameter int payload_width_p = 4,
    parameter int cnt_width_p     = 16,
    localparam int width_lp       = 2 * (x_cord_width_p + y_cord_width_p) + payload_width_p
) (
    input  logic                       clk_i,
    input  logic                       reset_n_i,

    input  logic [x_cord_width_p-1:0]  my_x_i,
    input  logic [y_cord_width_p-1:0]  my_y_i,

    input  logic                       req_v_i,
    output logic                       req_ready_o,
    input  logic [x_cord_width_p-1:0]  req_dest_x_i,
    input  logic [y_cord_width_p-1:0]  req_dest_y_i,
    input  logic [payload_width_p-1:0] req_payload_i,
    input  logic                       quiesce_i,

    output logic                       link_v_o,
    output logic [width_lp-1:0]        link_data_o,
    input  logic                       link_yumi_i,

    input  logic                       link_v_i,
    input  logic [width_lp-1:0]        link_data_i,
    output logic                       link_ready_and_o,

    output logic                       resp_v_o,
    output logic [payload_width_p-1:0] resp_payload_o,
    output logic [x_cord_width_p-1:0]  resp_src_x_o,
    output logic [y_cord_width_p-1:0]  resp_src_y_o,
    input  logic                       resp_yumi_i,

    output logic                       idle_o,
    output logic                       misroute_o,
    output logic [cnt_width_p-1:0]     sent_cnt_o,
    output logic [cnt_width_p-1:0]     recv_cnt_o
);

    // Field positions inside a packet.
    localparam int dest_y_lsb_lp  = x_cord_width_p;
    localparam int payload_lsb_lp = x_cord_width_p + y_cord_width_p;
    // Ejection entries drop the destination: it is only needed for the check.
    localparam int ej_width_lp    = width_lp - payload_lsb_lp;

    // -------------------------------------------------------------------------
    // Reset release. Every handshake that could change state is gated by
    // live_q, so on the first edge after an asynchronous deassert all other
    // flops have D == Q and cannot go metastable; only this flop samples the
    // release, which makes deassertion effectively synchronous.
    // -------------------------------------------------------------------------
    logic live_q;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            live_q <= 1'b0;
        end else begin
            live_q <= 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // Injection FIFO (2 entries)
    // -------------------------------------------------------------------------
    logic [width_lp-1:0] inj_mem_q [2];
    logic                inj_wptr_q, inj_wptr_d;
    logic                inj_rptr_q, inj_rptr_d;
    logic [1:0]          inj_cnt_q, inj_cnt_d;
    logic                inj_empty, inj_full;
    logic                inj_push, inj_pop;
    logic [width_lp-1:0] inj_packet;

    assign inj_empty  = (inj_cnt_q == 2'd0);
    assign inj_full   = (inj_cnt_q == 2'd2);
    // Ready depends only on registered occupancy, so a pop this cycle cannot
    // open the FIFO for a push in the same cycle.
    assign req_ready_o = live_q & ~inj_full & ~quiesce_i;
    assign inj_push    = req_v_i & req_ready_o;
    assign inj_pop     = link_yumi_i & ~inj_empty;
    assign inj_packet  = {my_y_i, my_x_i, req_payload_i, req_dest_y_i, req_dest_x_i};

    assign link_v_o    = ~inj_empty;
    assign link_data_o = inj_mem_q[inj_rptr_q];

    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned and a latch is never inferred.
    always_comb begin
        inj_wptr_d = inj_wptr_q;
        inj_rptr_d = inj_rptr_q;
        if (inj_push) inj_wptr_d = ~inj_wptr_q;
        if (inj_pop)  inj_rptr_d = ~inj_rptr_q;
        // NOTE: blocking assignments here because this is combinational logic;
        // the state registers below use non-blocking assignments only.
        inj_cnt_d = inj_cnt_q + {1'b0, inj_push} - {1'b0, inj_pop};
    end

    // NOTE: storage is deliberately not reset; the occupancy count qualifies
    // every read, so stale contents are never presented as valid.
    always_ff @(posedge clk_i) begin
        if (inj_push) begin
            inj_mem_q[inj_wptr_q] <= inj_packet;
        end
    end

    // -------------------------------------------------------------------------
    // Ejection FIFO (2 entries)
    // -------------------------------------------------------------------------
    logic [ej_width_lp-1:0]    ej_mem_q [2];
    logic                      ej_wptr_q, ej_wptr_d;
    logic                      ej_rptr_q, ej_rptr_d;
    logic [1:0]                ej_cnt_q, ej_cnt_d;
    logic                      ej_empty, ej_full;
    logic                      ej_push, ej_pop;
    logic [ej_width_lp-1:0]    ej_head;
    logic [x_cord_width_p-1:0] pkt_dest_x;
    logic [y_cord_width_p-1:0] pkt_dest_y;

    assign ej_empty         = (ej_cnt_q == 2'd0);
    assign ej_full          = (ej_cnt_q == 2'd2);
    assign link_ready_and_o = live_q & ~ej_full;
    assign ej_push          = link_v_i & link_ready_and_o;
    assign ej_pop           = resp_yumi_i & ~ej_empty;

    assign pkt_dest_x = link_data_i[0 +: x_cord_width_p];
    assign pkt_dest_y = link_data_i[dest_y_lsb_lp +: y_cord_width_p];

    assign ej_head        = ej_mem_q[ej_rptr_q];
    assign resp_v_o       = ~ej_empty;
    assign resp_payload_o = ej_head[0 +: payload_width_p];
    assign resp_src_x_o   = ej_head[payload_width_p +: x_cord_width_p];
    assign resp_src_y_o   = ej_head[payload_width_p + x_cord_width_p +: y_cord_width_p];

    always_comb begin
        ej_wptr_d = ej_wptr_q;
        ej_rptr_d = ej_rptr_q;
        if (ej_push) ej_wptr_d = ~ej_wptr_q;
        if (ej_pop)  ej_rptr_d = ~ej_rptr_q;
        ej_cnt_d = ej_cnt_q + {1'b0, ej_push} - {1'b0, ej_pop};
    end

    always_ff @(posedge clk_i) begin
        if (ej_push) begin
            ej_mem_q[ej_wptr_q] <= link_data_i[width_lp-1:payload_lsb_lp];
        end
    end

    // -------------------------------------------------------------------------
    // Destination check: sticky until reset; the packet is delivered anyway.
    // -------------------------------------------------------------------------
    logic misroute_q, misroute_d;

    always_comb begin
        misroute_d = misroute_q;
        if (ej_push && ((pkt_dest_x != my_x_i) || (pkt_dest_y != my_y_i))) begin
            misroute_d = 1'b1;
        end
    end

    assign misroute_o = misroute_q;
    assign idle_o     = inj_empty & ej_empty;

    // -------------------------------------------------------------------------
    // Control state registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            inj_wptr_q <= 1'b0;
            inj_rptr_q <= 1'b0;
            inj_cnt_q  <= 2'd0;
            ej_wptr_q  <= 1'b0;
            ej_rptr_q  <= 1'b0;
            ej_cnt_q   <= 2'd0;
            misroute_q <= 1'b0;
        end else begin
            inj_wptr_q <= inj_wptr_d;
            inj_rptr_q <= inj_rptr_d;
            inj_cnt_q  <= inj_cnt_d;
            ej_wptr_q  <= ej_wptr_d;
            ej_rptr_q  <= ej_rptr_d;
            ej_cnt_q   <= ej_cnt_d;
            misroute_q <= misroute_d;
        end
    end

    // -------------------------------------------------------------------------
    // Statistics counters (wrap modulo 2^cnt_width_p)
    // -------------------------------------------------------------------------
`ifdef BSG_MESH_ENDPOINT_STATS_EN
    logic [cnt_width_p-1:0] sent_cnt_q, sent_cnt_d;
    logic [cnt_width_p-1:0] recv_cnt_q, recv_cnt_d;

    always_comb begin
        sent_cnt_d = sent_cnt_q;
        recv_cnt_d = recv_cnt_q;
        if (inj_pop) sent_cnt_d = sent_cnt_q + cnt_width_p'(1);
        if (ej_push) recv_cnt_d = recv_cnt_q + cnt_width_p'(1);
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            sent_cnt_q <= '0;
            recv_cnt_q <= '0;
        end else begin
            sent_cnt_q <= sent_cnt_d;
            recv_cnt_q <= recv_cnt_d;
        end
    end

    assign sent_cnt_o = sent_cnt_q;
    assign recv_cnt_o = recv_cnt_q;
`else
    assign sent_cnt_o = '0;
    assign recv_cnt_o = '0;
`endif

    // -------------------------------------------------------------------------
    // Handshake protocol checks (ignored by synthesis)
    // -------------------------------------------------------------------------
    assert property (@(posedge clk_i) disable iff (!reset_n_i) !(link_yumi_i && !link_v_o))
        else $error("bsg_mesh_endpoint: link_yumi_i asserted while link_v_o is low");

    assert property (@(posedge clk_i) disable iff (!reset_n_i) !(resp_yumi_i && !resp_v_o))
        else $error("bsg_mesh_endpoint: resp_yumi_i asserted while resp_v_o is low");

endmodule

// File: tb/tb_bsg_mesh_endpoint.sv
// -----------------------------------------------------------------------------
// tb_bsg_mesh_endpoint
//
// Directed bench for bsg_mesh_endpoint with default parameters (8-bit packets).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// Injected packets and ejected responses are predicted when their handshake
// fires and compared when the DUT hands them on.
// -----------------------------------------------------------------------------
module tb_bsg_mesh_endpoint;

    logic       clk_i;
    logic       reset_n_i;
    logic       my_x_i, my_y_i;
    logic       req_v_i, req_ready_o;
    logic       req_dest_x_i, req_dest_y_i;
    logic [3:0] req_payload_i;
    logic       quiesce_i;
    logic       link_v_o;
    logic [7:0] link_data_o;
    logic       link_yumi_i;
    logic       link_v_i;
    logic [7:0] link_data_i;
    logic       link_ready_and_o;
    logic       resp_v_o;
    logic [3:0] resp_payload_o;
    logic       resp_src_x_o, resp_src_y_o;
    logic       resp_yumi_i;
    logic       idle_o, misroute_o;
    logic [15:0] sent_cnt_o, recv_cnt_o;

    bsg_mesh_endpoint dut (
        .clk_i            (clk_i),
        .reset_n_i        (reset_n_i),
        .my_x_i           (my_x_i),
        .my_y_i           (my_y_i),
        .req_v_i          (req_v_i),
        .req_ready_o      (req_ready_o),
        .req_dest_x_i     (req_dest_x_i),
        .req_dest_y_i     (req_dest_y_i),
        .req_payload_i    (req_payload_i),
        .quiesce_i        (quiesce_i),
        .link_v_o         (link_v_o),
        .link_data_o      (link_data_o),
        .link_yumi_i      (link_yumi_i),
        .link_v_i         (link_v_i),
        .link_data_i      (link_data_i),
        .link_ready_and_o (link_ready_and_o),
        .resp_v_o         (resp_v_o),
        .resp_payload_o   (resp_payload_o),
        .resp_src_x_o     (resp_src_x_o),
        .resp_src_y_o     (resp_src_y_o),
        .resp_yumi_i      (resp_yumi_i),
        .idle_o           (idle_o),
        .misroute_o       (misroute_o),
        .sent_cnt_o       (sent_cnt_o),
        .recv_cnt_o       (recv_cnt_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    // Scoreboard and reference state
    logic [7:0] inj_exp_q [$];
    logic [5:0] ej_exp_q [$];
    logic [5:0] offer_resp;
    logic       offer_dx, offer_dy;
    int         sent_model, recv_model;
    logic       misroute_model;
    logic       last_req_fire;
    int         checks, errors;
    int         accepts;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [7:0] pack(input logic sy, input logic sx, input logic [3:0] pl,
                                        input logic dy, input logic dx);
        return {sy, sx, pl, dy, dx};
    endfunction

    function automatic logic [15:0] exp_cnt(input int n);
`ifdef BSG_MESH_ENDPOINT_STATS_EN
        return 16'(n);
`else
        return 16'(0 * n);
`endif
    endfunction

    // Offer a packet from the router side.
    task automatic offer(input logic sy, input logic sx, input logic [3:0] pl,
                         input logic dy, input logic dx);
        link_v_i    = 1'b1;
        link_data_i = pack(sy, sx, pl, dy, dx);
        offer_resp  = {sy, sx, pl};
        offer_dx    = dx;
        offer_dy    = dy;
    endtask

    // Present a client request.
    task automatic request(input logic dy, input logic dx, input logic [3:0] pl);
        req_v_i       = 1'b1;
        req_dest_y_i  = dy;
        req_dest_x_i  = dx;
        req_payload_i = pl;
    endtask

    // One clock: decide which handshakes fire, update the scoreboard, and
    // return at the next falling edge.
    task automatic tick();
        logic       req_fire, ej_fire;
        logic [7:0] exp_pkt;
        logic [5:0] exp_resp;
        #1;
        req_fire = req_v_i & req_ready_o;
        ej_fire  = link_v_i & link_ready_and_o;
        if (link_yumi_i) begin
            check("inj_sb_nonempty", 32'(inj_exp_q.size() > 0), 32'd1);
            if (inj_exp_q.size() > 0) begin
                exp_pkt = inj_exp_q.pop_front();
                check("link_data", 32'(link_data_o), 32'(exp_pkt));
            end
            sent_model++;
        end
        if (req_fire) begin
            inj_exp_q.push_back(pack(my_y_i, my_x_i, req_payload_i, req_dest_y_i, req_dest_x_i));
        end
        if (resp_yumi_i) begin
            check("ej_sb_nonempty", 32'(ej_exp_q.size() > 0), 32'd1);
            if (ej_exp_q.size() > 0) begin
                exp_resp = ej_exp_q.pop_front();
                check("resp_fields", 32'({resp_src_y_o, resp_src_x_o, resp_payload_o}), 32'(exp_resp));
            end
        end
        if (ej_fire) begin
            ej_exp_q.push_back(offer_resp);
            recv_model++;
            if (offer_dx != my_x_i || offer_dy != my_y_i) misroute_model = 1'b1;
        end
        last_req_fire = req_fire;
        @(negedge clk_i);
    endtask

    task automatic check_in_reset(input string tag);
        check({tag, "_link_v"}, 32'(link_v_o), 32'd0);
        check({tag, "_resp_v"}, 32'(resp_v_o), 32'd0);
        check({tag, "_misroute"}, 32'(misroute_o), 32'd0);
        check({tag, "_link_ready"}, 32'(link_ready_and_o), 32'd0);
        check({tag, "_sent_cnt"}, 32'(sent_cnt_o), 32'd0);
        check({tag, "_recv_cnt"}, 32'(recv_cnt_o), 32'd0);
    endtask

    task automatic release_and_check(input string tag);
        @(negedge clk_i);
        @(negedge clk_i);
        reset_n_i = 1'b1;
        @(negedge clk_i);
        check({tag, "_idle"}, 32'(idle_o), 32'd1);
        check({tag, "_link_ready"}, 32'(link_ready_and_o), 32'd1);
        check({tag, "_req_ready"}, 32'(req_ready_o), 32'd1);
        check({tag, "_link_v"}, 32'(link_v_o), 32'd0);
        check({tag, "_resp_v"}, 32'(resp_v_o), 32'd0);
    endtask

    // Pulse reset in the middle of a high phase and check the asynchronous
    // response before any further clock edge.
    task automatic pulse_reset(input string tag, input logic mx, input logic my);
        @(posedge clk_i);
        #2;
        reset_n_i   = 1'b0;
        req_v_i     = 1'b0;
        link_v_i    = 1'b0;
        link_yumi_i = 1'b0;
        resp_yumi_i = 1'b0;
        quiesce_i   = 1'b0;
        #1;
        check_in_reset(tag);
        my_x_i = mx;
        my_y_i = my;
        inj_exp_q.delete();
        ej_exp_q.delete();
        sent_model     = 0;
        recv_model     = 0;
        misroute_model = 1'b0;
        release_and_check({tag, "_rel"});
    endtask

    initial begin
        logic [7:0] fmt_exp;
        checks = 0;
        errors = 0;
        sent_model = 0;
        recv_model = 0;
        misroute_model = 1'b0;
        reset_n_i = 1'b0;
        my_x_i = 1'b1;
        my_y_i = 1'b0;
        req_v_i = 1'b0;
        req_dest_x_i = 1'b0;
        req_dest_y_i = 1'b0;
        req_payload_i = 4'h0;
        quiesce_i = 1'b0;
        link_yumi_i = 1'b0;
        link_v_i = 1'b0;
        link_data_i = 8'h00;
        resp_yumi_i = 1'b0;
        offer_resp = 6'h0;
        offer_dx = 1'b0;
        offer_dy = 1'b0;

        // ---- power-on reset, tile (1,0) ----
        @(negedge clk_i);
        @(negedge clk_i);
        check_in_reset("por");
        check("por_idle", 32'(idle_o), 32'd1);
        release_and_check("por_rel");

        // ---- packet format: dest (0,1), payload A ----
        request(1'b1, 1'b0, 4'hA);
        check("fmt_link_v_before", 32'(link_v_o), 32'd0);
        tick();
        req_v_i = 1'b0;
        fmt_exp = 8'h6A;
        check("fmt_link_v_after", 32'(link_v_o), 32'd1);
        check("fmt_literal", 32'(link_data_o), 32'(fmt_exp));
        link_yumi_i = 1'b1;
        tick();
        link_yumi_i = 1'b0;
        check("fmt_sent_cnt", 32'(sent_cnt_o), 32'(exp_cnt(sent_model)));

        // ---- injection back-pressure: three requests, no yumi ----
        accepts = 0;
        request(1'b1, 1'b1, 4'h1);
        tick();
        accepts += int'(last_req_fire);
        request(1'b0, 1'b1, 4'h2);
        tick();
        accepts += int'(last_req_fire);
        request(1'b1, 1'b0, 4'h3);
        check("bp_ready_full", 32'(req_ready_o), 32'd0);
        tick();
        accepts += int'(last_req_fire);
        check("bp_accepts", 32'(accepts), 32'd2);
        link_yumi_i = 1'b1;
        check("bp_ready_same_cycle", 32'(req_ready_o), 32'd0);
        tick();
        link_yumi_i = 1'b0;
        check("bp_ready_next_cycle", 32'(req_ready_o), 32'd1);
        check("bp_sent_cnt", 32'(sent_cnt_o), 32'(exp_cnt(sent_model)));
        tick();
        req_v_i = 1'b0;
        link_yumi_i = 1'b1;
        tick();
        tick();
        link_yumi_i = 1'b0;
        check("bp_drained", 32'(link_v_o), 32'd0);

        // ---- injection streaming: push and pop every cycle at occupancy 1 ----
        request(1'b0, 1'b0, 4'hB);
        tick();
        accepts = 0;
        for (int i = 0; i < 4; i++) begin
            request(1'(i), 1'(i + 1), 4'(4'hC + i));
            link_yumi_i = 1'b1;
            tick();
            accepts += int'(last_req_fire);
        end
        check("inj_stream_accepts", 32'(accepts), 32'd4);
        req_v_i = 1'b0;
        tick();
        link_yumi_i = 1'b0;
        check("inj_stream_idle", 32'(idle_o), 32'd1);
        check("inj_stream_sent_cnt", 32'(sent_cnt_o), 32'(exp_cnt(sent_model)));

        // ---- ejection full, then streaming ----
        offer(1'b1, 1'b1, 4'h5, 1'b0, 1'b1);
        tick();
        offer(1'b0, 1'b1, 4'h6, 1'b0, 1'b1);
        tick();
        offer(1'b1, 1'b0, 4'h7, 1'b0, 1'b1);
        check("ej_ready_full", 32'(link_ready_and_o), 32'd0);
        check("ej_resp_v", 32'(resp_v_o), 32'd1);
        tick();
        check("ej_full_recv_cnt", 32'(recv_cnt_o), 32'(exp_cnt(recv_model)));
        resp_yumi_i = 1'b1;
        check("ej_ready_same_cycle", 32'(link_ready_and_o), 32'd0);
        tick();
        check("ej_ready_next_cycle", 32'(link_ready_and_o), 32'd1);
        for (int i = 0; i < 4; i++) begin
            offer(1'(i), 1'(i + 1), 4'(4'h7 + i), 1'b0, 1'b1);
            check("ej_stream_ready", 32'(link_ready_and_o), 32'd1);
            tick();
            check("ej_stream_recv_cnt", 32'(recv_cnt_o), 32'(exp_cnt(recv_model)));
        end
        link_v_i = 1'b0;
        tick();
        resp_yumi_i = 1'b0;
        check("ej_drained", 32'(resp_v_o), 32'd0);
        check("ej_no_misroute", 32'(misroute_o), 32'(misroute_model));

        // ---- reset mid-transfer discards buffered packets, tile becomes (0,0) ----
        request(1'b1, 1'b1, 4'h4);
        offer(1'b0, 1'b0, 4'h8, 1'b0, 1'b1);
        tick();
        check("mid_link_v", 32'(link_v_o), 32'd1);
        check("mid_resp_v", 32'(resp_v_o), 32'd1);
        pulse_reset("mid", 1'b0, 1'b0);

        // ---- misroute: dest (1,1) at tile (0,0) ----
        offer(1'b1, 1'b1, 4'h9, 1'b1, 1'b1);
        check("mr_before", 32'(misroute_o), 32'd0);
        tick();
        link_v_i = 1'b0;
        check("mr_set", 32'(misroute_o), 32'(misroute_model));
        check("mr_delivered", 32'(resp_v_o), 32'd1);
        resp_yumi_i = 1'b1;
        tick();
        resp_yumi_i = 1'b0;
        tick();
        tick();
        check("mr_sticky_idle", 32'(misroute_o), 32'd1);
        offer(1'b0, 1'b1, 4'h3, 1'b0, 1'b0);
        tick();
        link_v_i = 1'b0;
        resp_yumi_i = 1'b1;
        tick();
        resp_yumi_i = 1'b0;
        check("mr_sticky_good_pkt", 32'(misroute_o), 32'd1);

        // ---- quiesce with two packets queued ----
        request(1'b1, 1'b1, 4'hD);
        tick();
        request(1'b0, 1'b1, 4'hE);
        tick();
        request(1'b1, 1'b0, 4'hF);
        quiesce_i = 1'b1;
        check("q_ready_low", 32'(req_ready_o), 32'd0);
        check("q_not_idle", 32'(idle_o), 32'd0);
        link_yumi_i = 1'b1;
        tick();
        check("q_ready_still_low", 32'(req_ready_o), 32'd0);
        check("q_not_idle_one_left", 32'(idle_o), 32'd0);
        tick();
        link_yumi_i = 1'b0;
        check("q_idle_after_drain", 32'(idle_o), 32'd1);
        check("q_ready_quiesced", 32'(req_ready_o), 32'd0);
        req_v_i = 1'b0;
        quiesce_i = 1'b0;
        tick();
        check("q_ready_restored", 32'(req_ready_o), 32'd1);
        check("sb_inj_empty", 32'(inj_exp_q.size()), 32'd0);
        check("sb_ej_empty", 32'(ej_exp_q.size()), 32'd0);
        check("final_sent_cnt", 32'(sent_cnt_o), 32'(exp_cnt(sent_model)));
        check("final_recv_cnt", 32'(recv_cnt_o), 32'(exp_cnt(recv_model)));

        // ---- misroute clears only on reset ----
        pulse_reset("end", 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
